// File: rtl/bf_uart_port_pkg.sv
// Shared types and defaults for the brainfuck_uP UART port bridge.
//   ser_state_t : state encoding used by both the RX and TX serialisers
//   byte_t      : one CPU/UART data byte
package bf_uart_port_pkg;

  localparam int unsigned BYTE_W                = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT  = 104;
  localparam int unsigned DEFAULT_TX_FIFO_DEPTH = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/bf_byte_fifo.sv
// Small byte FIFO queuing CPU '.' writes ahead of the UART transmitter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write request and data (dropped when full unless popping)
//   pop, dout   : read request; dout is combinational from the read pointer
//   empty, full : occupancy flags
module bf_byte_fifo
  import bf_uart_port_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_TX_FIFO_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  empty,
  output logic  full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  byte_t         mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rp[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + PW'(1);
      if (pop_ok)  rp <= rp + PW'(1);
    end
  end

  // Storage; a simultaneous pop has already read the old entry through dout.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bf_uart_port.sv
// Port bridge between the brainfuck_uP I/O strobes and an 8N1 UART.
// Ports:
//   bfup_clk, reset : clock, asynchronous active-low reset
//   outPort, portWR : CPU output byte and active-low write strobe (queued for TX)
//   portRD          : active-low read strobe; its rising edge consumes inPort
//   inPort, incoming: received byte and its unread flag
//   uart_rx, uart_tx: serial in (asynchronous) / serial out, both idle high
//   tx_busy         : FIFO non-empty or a frame in flight
//   rx_overrun, framing_err, tx_overflow : single-cycle error pulses
module bf_uart_port
  import bf_uart_port_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TX_FIFO_DEPTH = DEFAULT_TX_FIFO_DEPTH
) (
  input  logic       bfup_clk,
  input  logic       reset,
  input  logic [7:0] outPort,
  input  logic       portWR,
  input  logic       portRD,
  output logic [7:0] inPort,
  output logic       incoming,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       framing_err,
  output logic       tx_overflow
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(BYTE_W);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(BYTE_W - 1);

  logic          wr_q, rd_q, wr_evt, rd_done, slot_free;
  logic          rx_meta, rxs;

  ser_state_t    rx_state, rx_state_n;
  logic [TW-1:0] rx_tmr, rx_tmr_n;
  logic [IW-1:0] rx_idx, rx_idx_n;
  byte_t         rx_shr, rx_shr_n;
  logic          rx_done, rx_done_n, ferr_n;

  ser_state_t    tx_state, tx_state_n;
  logic [TW-1:0] tx_tmr, tx_tmr_n;
  logic [IW-1:0] tx_idx, tx_idx_n;
  byte_t         tx_shr, tx_shr_n;
  logic          tx_line_n, tx_pop_c;

  byte_t         fifo_dout;
  logic          fifo_empty, fifo_full, fifo_push;

  assign wr_evt    = wr_q & ~portWR;
  assign rd_done   = ~rd_q & portRD;
  assign slot_free = ~incoming | rd_done;
  assign fifo_push = wr_evt & (~fifo_full | tx_pop_c);
  assign tx_busy   = ~fifo_empty | (tx_state != ST_IDLE);

  bf_byte_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (bfup_clk),
    .rst_n (reset),
    .push  (fifo_push),
    .din   (outPort),
    .pop   (tx_pop_c),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // RX next-state: start bit checked at mid-bit, then one sample per bit period.
  always_comb begin
    rx_state_n = rx_state;
    rx_tmr_n   = rx_tmr + TW'(1);
    rx_idx_n   = rx_idx;
    rx_shr_n   = rx_shr;
    rx_done_n  = 1'b0;
    ferr_n     = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        rx_tmr_n = '0;
        if (!rxs) rx_state_n = ST_START;
      end
      ST_START: begin
        if (rx_tmr == T_HALF) begin
          rx_tmr_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_tmr == T_LAST) begin
          rx_tmr_n = '0;
          rx_shr_n = {rxs, rx_shr[BYTE_W-1:1]};
          if (rx_idx == I_LAST) rx_state_n = ST_STOP;
          else                  rx_idx_n   = rx_idx + IW'(1);
        end
      end
      ST_STOP: begin
        if (rx_tmr == T_LAST) begin
          rx_tmr_n   = '0;
          rx_state_n = ST_IDLE;
          rx_done_n  = rxs;
          ferr_n     = ~rxs;
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  // TX next-state: the line value is computed one cycle ahead so uart_tx is a flop.
  always_comb begin
    tx_state_n = tx_state;
    tx_tmr_n   = tx_tmr + TW'(1);
    tx_idx_n   = tx_idx;
    tx_shr_n   = tx_shr;
    tx_line_n  = uart_tx;
    tx_pop_c   = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        tx_tmr_n  = '0;
        tx_line_n = 1'b1;
        if (!fifo_empty) begin
          tx_pop_c   = 1'b1;
          tx_shr_n   = fifo_dout;
          tx_line_n  = 1'b0;
          tx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (tx_tmr == T_LAST) begin
          tx_tmr_n   = '0;
          tx_idx_n   = '0;
          tx_line_n  = tx_shr[0];
          tx_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tmr == T_LAST) begin
          tx_tmr_n = '0;
          if (tx_idx == I_LAST) begin
            tx_line_n  = 1'b1;
            tx_state_n = ST_STOP;
          end else begin
            tx_shr_n  = tx_shr >> 1;
            tx_line_n = tx_shr[1];
            tx_idx_n  = tx_idx + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tx_tmr == T_LAST) begin
          tx_tmr_n   = '0;
          tx_state_n = ST_IDLE;
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rx_state    <= ST_IDLE;
      rx_tmr      <= '0;
      rx_idx      <= '0;
      rx_shr      <= '0;
      rx_done     <= 1'b0;
      tx_state    <= ST_IDLE;
      tx_tmr      <= '0;
      tx_idx      <= '0;
      tx_shr      <= '0;
      uart_tx     <= 1'b1;
      inPort      <= '0;
      incoming    <= 1'b0;
      rx_overrun  <= 1'b0;
      framing_err <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      wr_q        <= portWR;
      rd_q        <= portRD;
      rx_meta     <= uart_rx;
      rxs         <= rx_meta;
      rx_state    <= rx_state_n;
      rx_tmr      <= rx_tmr_n;
      rx_idx      <= rx_idx_n;
      rx_shr      <= rx_shr_n;
      rx_done     <= rx_done_n;
      tx_state    <= tx_state_n;
      tx_tmr      <= tx_tmr_n;
      tx_idx      <= tx_idx_n;
      tx_shr      <= tx_shr_n;
      uart_tx     <= tx_line_n;
      framing_err <= ferr_n;
      rx_overrun  <= rx_done & ~slot_free;
      tx_overflow <= wr_evt & fifo_full & ~tx_pop_c;
      // A read completing in the delivery cycle frees the slot for the new byte.
      if (rx_done) begin
        if (slot_free) begin
          inPort   <= rx_shr;
          incoming <= 1'b1;
        end
      end else if (rd_done) begin
        incoming <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bf_uart_port.sv
// Scoreboard bench for bf_uart_port (CLKS_PER_BIT=8, TX_FIFO_DEPTH=4).
module tb_bf_uart_port;

  localparam int CPB     = 8;
  localparam int EV_DLV  = 0;
  localparam int EV_CLR  = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_FERR = 3;
  localparam int EV_TOVF = 4;
  localparam int EV_IDLE = 5;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } tx_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] outPort;
  logic       portWR, portRD, uart_rx;
  logic [7:0] inPort;
  logic       incoming, uart_tx, tx_busy, rx_overrun, framing_err, tx_overflow;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  s, r, w;
  ev_t ev_q[$];
  tx_t tx_q[$];

  logic [7:0] t4_bytes [6] = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hFF, 8'h77};

  bf_uart_port #(
    .CLKS_PER_BIT  (CPB),
    .TX_FIFO_DEPTH (4)
  ) dut (
    .bfup_clk    (clk),
    .reset       (reset),
    .outPort     (outPort),
    .portWR      (portWR),
    .portRD      (portRD),
    .inPort      (inPort),
    .incoming    (incoming),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx),
    .tx_busy     (tx_busy),
    .rx_overrun  (rx_overrun),
    .framing_err (framing_err),
    .tx_overflow (tx_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_DLV:  return "deliver";
      EV_CLR:  return "clear";
      EV_OVR:  return "rx_overrun";
      EV_FERR: return "framing_err";
      EV_TOVF: return "tx_overflow";
      default: return "tx_idle";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic strobe_wr(input logic [7:0] d);
    outPort = d;
    portWR  = 1'b0;
    tick(1);
    portWR  = 1'b1;
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    ev_q.push_back(e);
  endtask

  task automatic expect_tx(input logic [7:0] d, input int c);
    tx_t e;
    e.data = d;
    e.cyc  = c;
    tx_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic take_ev(input int k, input logic [7:0] d);
    ev_t e;
    vectors++;
    if (ev_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s data=%h at cycle %0d", kname(k), d, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got %s data=%h cycle=%0d, expected %s data=%h cycle=%0d",
                 kname(k), d, cyc, kname(e.kind), e.data, e.cyc);
      end
    end
  endtask

  // Event monitor: CPU-side and status outputs
  logic       prev_inc = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_inport = 8'h00;

  always @(negedge clk) begin
    if (incoming === 1'b1 && (prev_inc !== 1'b1 || inPort !== prev_inport))
      take_ev(EV_DLV, inPort);
    if (incoming === 1'b0 && prev_inc === 1'b1) take_ev(EV_CLR, 8'h00);
    if (rx_overrun === 1'b1)  take_ev(EV_OVR, 8'h00);
    if (framing_err === 1'b1) take_ev(EV_FERR, 8'h00);
    if (tx_overflow === 1'b1) take_ev(EV_TOVF, 8'h00);
    if (tx_busy === 1'b0 && prev_busy === 1'b1) take_ev(EV_IDLE, 8'h00);
    prev_inc    = incoming;
    prev_busy   = tx_busy;
    prev_inport = inPort;
  end

  // Frame monitor: captures 80 cycles of uart_tx from each start bit
  int          tx_c0;
  logic [79:0] tx_got;
  bit          tx_abort;

  task automatic check_frame();
    tx_t        e;
    logic [9:0] fr;
    logic [7:0] dec;
    bit         ok;
    for (int i = 0; i < 8; i++) dec[i] = tx_got[8 * (i + 1) + 4];
    vectors++;
    if (tx_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected tx frame data=%h start cycle %0d", dec, tx_c0);
    end else begin
      e  = tx_q.pop_front();
      fr = {1'b1, e.data, 1'b0};
      ok = (tx_c0 == e.cyc);
      for (int t = 0; t < 80; t++) if (tx_got[t] !== fr[t / 8]) ok = 0;
      if (!ok) begin
        miscompares++;
        $display("FAIL tx frame: got data=%h start=%0d bits=%h, expected data=%h start=%0d",
                 dec, tx_c0, tx_got, e.data, e.cyc);
      end
    end
  endtask

  always begin
    @(negedge clk);
    if (reset === 1'b1 && uart_tx === 1'b0) begin
      tx_c0     = cyc;
      tx_abort  = 0;
      tx_got[0] = uart_tx;
      for (int t = 1; t < 80; t++) begin
        @(negedge clk);
        if (reset !== 1'b1) tx_abort = 1;
        tx_got[t] = uart_tx;
      end
      if (!tx_abort) check_frame();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    portWR  = 1'b1;
    portRD  = 1'b1;
    uart_rx = 1'b1;
    outPort = 8'h00;
    #2 reset = 1'b0;
    tick(3);
    check("reset uart_tx", {7'd0, uart_tx}, 8'h01);
    check("reset inPort", inPort, 8'h00);
    check("reset incoming", {7'd0, incoming}, 8'h00);
    check("reset tx_busy", {7'd0, tx_busy}, 8'h00);
    check("reset rx_overrun", {7'd0, rx_overrun}, 8'h00);
    check("reset framing_err", {7'd0, framing_err}, 8'h00);
    check("reset tx_overflow", {7'd0, tx_overflow}, 8'h00);
    reset = 1'b1;
    tick(5);

    // 1: receive 0x41, then a 21-cycle read
    s = cyc;
    expect_ev(EV_DLV, 8'h41, s + 81);
    send_rx(8'h41, 1'b1);
    tick(5);
    r = cyc;
    portRD = 1'b0;
    tick(21);
    portRD = 1'b1;
    expect_ev(EV_CLR, 8'h00, r + 22);
    tick(5);

    // 2: overrun, then a read completing in the delivery cycle
    s = cyc;
    expect_ev(EV_DLV, 8'h41, s + 81);
    send_rx(8'h41, 1'b1);
    s = cyc;
    expect_ev(EV_OVR, 8'h00, s + 81);
    send_rx(8'h42, 1'b1);
    s = cyc;
    expect_ev(EV_DLV, 8'h42, s + 81);
    fork
      send_rx(8'h42, 1'b1);
      begin
        tick(70);
        portRD = 1'b0;
        tick(10);
        portRD = 1'b1;
      end
    join
    tick(3);
    r = cyc;
    portRD = 1'b0;
    tick(2);
    portRD = 1'b1;
    expect_ev(EV_CLR, 8'h00, r + 3);
    tick(5);

    // 3: two writes, back-to-back frames
    w = cyc;
    expect_tx(8'h48, w + 2);
    expect_tx(8'h69, w + 83);
    expect_ev(EV_IDLE, 8'h00, w + 163);
    strobe_wr(8'h48);
    tick(2);
    strobe_wr(8'h69);
    tick(200);

    // 4: six writes into a 4-deep queue
    w = cyc;
    for (int k = 0; k < 5; k++) expect_tx(t4_bytes[k], w + 2 + 81 * k);
    expect_ev(EV_TOVF, 8'h00, w + 16);
    expect_ev(EV_IDLE, 8'h00, w + 406);
    for (int k = 0; k < 6; k++) begin
      strobe_wr(t4_bytes[k]);
      tick(2);
    end
    tick(420);

    // 5: start glitch, then a frame with a low stop bit
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    s = cyc;
    expect_ev(EV_FERR, 8'h00, s + 80);
    send_rx(8'h5A, 1'b0);
    tick(30);
    check("incoming after framing error", {7'd0, incoming}, 8'h00);

    // 6: reset in the middle of a transmitted frame
    strobe_wr(8'hC3);
    tick(30);
    @(posedge clk);
    #2;
    expect_ev(EV_IDLE, 8'h00, cyc);
    reset = 1'b0;
    #1;
    check("uart_tx at reset", {7'd0, uart_tx}, 8'h01);
    check("tx_busy at reset", {7'd0, tx_busy}, 8'h00);
    tick(3);
    reset = 1'b1;
    tick(200);
    check("incoming after reset", {7'd0, incoming}, 8'h00);

    tick(10);
    while (ev_q.size() > 0) begin
      ev_t e;
      e = ev_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing %s data=%h expected cycle %0d", kname(e.kind), e.data, e.cyc);
    end
    while (tx_q.size() > 0) begin
      tx_t e;
      e = tx_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing tx frame data=%h expected start %0d", e.data, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
